booth_mult_arbiter: RTL
=======================

// Module: booth_mult_arbiter
// PURPOSE
//  Shares one 6-bit signed Booth multiplier (start/ready handshake) between N requesters.
//  Round-robin arbitration: the block latches the winner's operands and pulses the multiplier's start.
//  It then waits for ready and returns the 12-bit product to the winner with a one-cycle done pulse.
//  Sits between client blocks and the multiplier datapath+controller pair.
// PARAMETERS
//  N        4   number of requesters (2..8)
//  TIMEOUT  32  max WAIT cycles before abort (used only with BOOTH_ARB_TIMEOUT_EN)
// PORTS
//  clk           in   1     clock, all logic on posedge
//  rst           in   1     synchronous, active-high reset
//  req           in   N     per-requester request level
//  a_flat        in   6*N   multiplicand for requester i at [6i+5:6i], two's complement
//  b_flat        in   6*N   multiplier for requester i at [6i+5:6i], two's complement
//  gnt           out  N     one-hot grant, high from ISSUE through DONE
//  done          out  N     one-hot, one-cycle completion pulse
//  product       out  12    signed result, valid while done != 0, held until next done
//  err           out  1     abort flag, valid with done
//  busy          out  1     high whenever state != IDLE
//  mult_start    out  1     one-cycle start pulse to the multiplier
//  mult_a        out  6     latched multiplicand
//  mult_b        out  6     latched multiplier
//  mult_ready    in   1     multiplier completion, product valid this cycle
//  mult_product  in   12    multiplier result
// BEHAVIOUR
//  Reset: state=IDLE, ptr=0; gnt, done, err, busy, mult_start, mult_a, mult_b and product are all 0.
//  Reset mid-operation: the transaction is abandoned, no done is pulsed.
//  FSM states:
//   IDLE: if req!=0, pick the first set req[i] scanning i = ptr, ptr+1, ... mod N.
//         Register g=i, set gnt[g], latch a/b[g] into mult_a/mult_b, then go to ISSUE.
//   ISSUE: mult_start=1 for exactly this cycle, then go to WAIT.
//   WAIT: on mult_ready, capture mult_product into product, err=0, then go to DONE.
//         mult_ready seen in any other state is ignored.
//   DONE: done[g]=1 for this cycle; ptr <= (g+1) mod N; gnt cleared on exit; go to IDLE.
//  Latency from req seen in IDLE to done: 3 cycles + multiplier latency (start to ready).
//  Minimum gap between services: 1 IDLE cycle.
//  Operands are sampled once, on the IDLE->ISSUE edge; later changes to a/b have no effect.
//  If req[g] drops after grant, the service still completes and done[g] still pulses.
//  A requester wanting another multiply keeps req high. It is re-arbitrated behind the others.
//  Simultaneous requests: the lowest index at or after ptr wins; ptr wraps from N-1 to 0.
//  A requester never waits more than N-1 other services.
//  Product width: full 12-bit signed result, passed through with no truncation or rounding.
//  -32*-32 = +1024 (12'h400) must be representable.
// CONFIGURATION
//  BOOTH_ARB_TIMEOUT_EN defined:
//   - A counter clears on entry to WAIT and increments each WAIT cycle.
//   - If it reaches TIMEOUT-1 without mult_ready, go to DONE with err=1 and product=0.
//   - Next IDLE cycle: mult_start is not reasserted for that request; ptr advances normally.
//  BOOTH_ARB_TIMEOUT_EN undefined: WAIT lasts until mult_ready; err is tied to 0; no counter.
// TESTING
//  1 Reset: assert rst 2 cycles with req=4'hF -> all outputs 0, no mult_start during or in the cycle after.
//  2 Single: req=4'b0001, a0=5, b0=3 -> gnt=0001, one mult_start, done=0001, product=12'd15.
//    Signed: a0=-3, b0=7 -> product=12'hFEB (-21).
//    Corner: a0=-32, b0=-32 -> product=12'h400.
//  3 Round-robin: req=4'hF held -> grant order 0,1,2,3,0; each done pulse exactly 1 cycle.
//  4 Wrap/ptr: after serving req 3, assert req=4'b1001 -> requester 0 wins.
//    Next grant goes to requester 3.
//  5 Drop/operand change: deassert req1 and change a1 in WAIT -> done[1] still pulses.
//    product uses the originally latched operands.
//  6 Timeout (macro on, TIMEOUT=32): stub holds mult_ready=0.
//    -> done[g] with err=1, product=0, exactly 32 WAIT cycles after ISSUE.
//    Macro off: still busy after 100 cycles.

Source files
------------

// File: rtl/booth_mult_arbiter_if.sv
// Handshake bus between the arbiter and the shared 6x6 signed Booth multiplier.
// The arbiter drives start/operands as master; the multiplier answers with ready/product.
interface booth_mult_if;
   logic        mult_start;
   logic [5:0]  mult_a;
   logic [5:0]  mult_b;
   logic        mult_ready;
   logic [11:0] mult_product;

   modport master (
      output mult_start,
      output mult_a,
      output mult_b,
      input  mult_ready,
      input  mult_product
   );

   modport slave (
      input  mult_start,
      input  mult_a,
      input  mult_b,
      output mult_ready,
      output mult_product
   );
endinterface

// File: rtl/booth_mult_arbiter.sv
// Round-robin arbiter sharing one signed Booth multiplier between N requesters.
// Optional WAIT-state abort timer enabled by defining BOOTH_ARB_TIMEOUT_EN.
module booth_mult_arbiter #(
   parameter int N       = 4,
   parameter int TIMEOUT = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N-1:0]     i_req,
   input  logic [6*N-1:0]   i_a_flat,
   input  logic [6*N-1:0]   i_b_flat,
   output logic [N-1:0]     o_gnt,
   output logic [N-1:0]     o_done,
   output logic [11:0]      o_product,
   output logic             o_err,
   output logic             o_busy,
   booth_mult_if.master     m_mult
);

   localparam int GW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

   state_t        r_state;
   state_t        w_state_next;
   logic [GW-1:0] r_ptr;
   logic [GW-1:0] r_g;
   logic [GW-1:0] w_pick;
   logic          w_found;
   logic [N-1:0]  w_onehot;
   logic [5:0]    r_mult_a;
   logic [5:0]    r_mult_b;
   logic [11:0]   r_product;
   logic          w_timeout;

`ifdef BOOTH_ARB_TIMEOUT_EN
   localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   logic [CW-1:0] r_wait_cnt;
   logic          r_err;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wait_cnt <= '0;
      end else if (r_state == S_ISSUE) begin
         r_wait_cnt <= '0;
      end else if (r_state == S_WAIT) begin
         r_wait_cnt <= r_wait_cnt + 1'b1;
      end
   end

   // A late ready on the final counted cycle still wins over the abort.
   assign w_timeout = (r_state == S_WAIT) && !m_mult.mult_ready &&
                      (r_wait_cnt == CW'(TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_err <= 1'b0;
      end else if (r_state == S_WAIT) begin
         if (m_mult.mult_ready) begin
            r_err <= 1'b0;
         end else if (w_timeout) begin
            r_err <= 1'b1;
         end
      end
   end

   assign o_err = r_err;
`else
   assign w_timeout = 1'b0;
   assign o_err     = 1'b0;
`endif

   // Scan from the highest offset down so the lowest offset from r_ptr is kept.
   always_comb begin
      logic [GW:0]   w_sum;
      logic [GW-1:0] w_idx;
      w_found = 1'b0;
      w_pick  = '0;
      w_sum   = '0;
      w_idx   = '0;
      for (int k = N - 1; k >= 0; k--) begin
         w_sum = {1'b0, r_ptr} + (GW + 1)'(k);
         if (w_sum >= (GW + 1)'(N)) begin
            w_sum = w_sum - (GW + 1)'(N);
         end
         w_idx = w_sum[GW-1:0];
         if (i_req[w_idx]) begin
            w_found = 1'b1;
            w_pick  = w_idx;
         end
      end
   end

   for (genvar gi = 0; gi < N; gi++) begin : g_onehot
      assign w_onehot[gi] = (r_g == GW'(gi));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:  if (w_found) w_state_next = S_ISSUE;
         S_ISSUE: w_state_next = S_WAIT;
         S_WAIT:  if (m_mult.mult_ready || w_timeout) w_state_next = S_DONE;
         S_DONE:  w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   always_comb begin
      o_gnt             = '0;
      o_done            = '0;
      o_busy            = (r_state != S_IDLE);
      m_mult.mult_start = (r_state == S_ISSUE);
      if (r_state != S_IDLE) begin
         o_gnt = w_onehot;
      end
      if (r_state == S_DONE) begin
         o_done = w_onehot;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ptr     <= '0;
         r_g       <= '0;
         r_mult_a  <= '0;
         r_mult_b  <= '0;
         r_product <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_found) begin
                  r_g      <= w_pick;
                  r_mult_a <= i_a_flat[6*w_pick +: 6];
                  r_mult_b <= i_b_flat[6*w_pick +: 6];
               end
            end
            S_WAIT: begin
               if (m_mult.mult_ready) begin
                  r_product <= m_mult.mult_product;
               end else if (w_timeout) begin
                  r_product <= '0;
               end
            end
            S_DONE: begin
               r_ptr <= (r_g == GW'(N - 1)) ? '0 : r_g + 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign m_mult.mult_a = r_mult_a;
   assign m_mult.mult_b = r_mult_b;
   assign o_product     = r_product;

endmodule
